stage_mem: RTL

- Memory stage of the ARM-style five-stage pipeline; sits between the EX/MEM pipeline register and the ID stage's write-back inputs.
- Runs an FSM that performs loads and stores through a 16-bit external SRAM, using two half-word accesses per 32-bit word.
- Holds the pipeline with `ready` while an access is in flight.
- Contains the MEM/WB register, so it is the producer of the write-back bus (`wbWbEn`, `wbValue`, `wbDest`) that the ID stage consumes.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/sram_ctrl.sv | 104 ++++++++++
 rtl/stage_mem.sv | 85 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the memory stage and its SRAM controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Memory-access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } memState_e;

  // Byte address that maps onto SRAM word 0
  localparam int unsigned BASE_ADDR_DEFAULT = 1024;

  // Write-back bundle: {wbEn, value[31:0], dest[3:0]}
  localparam int WB_BUS_W = 37;

  typedef struct packed {
    logic        wbEn;
    logic [31:0] value;
    logic [3:0]  dest;
  } wbBus_t;

endpackage

// File: rtl/sram_ctrl.sv
// 32-bit load/store engine over a 16-bit SRAM, two half-word phases per word.
// Latency: 2*(WAIT_CYCLES+1) phase cycles plus a DONE cycle after the request cycle.
// Backpressure: ready low from the request cycle until DONE; requester must hold inputs.
//
// Ports: clk/rst (sync, active-high); reqRead/reqWrite (read already has priority
// upstream); wordAddr/wrData from the requester; ready and rdWord back to it;
// sramAddr/sramDqOut/sramDqIn/sramDqOe/sramWeN to the SRAM pins.
import pipe_pkg::*;

module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reqRead,
  input  logic               reqWrite,
  input  logic [SRAM_AW-2:0] wordAddr,
  input  logic [31:0]        wrData,
  output logic               ready,
  output logic [31:0]        rdWord,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN
);

  memState_e   state;
  memState_e   nextState;
  logic [2:0]  phaseCnt;
  logic        phaseLast;
  logic        req;
  logic [15:0] loHalf;
  logic [15:0] hiHalf;

  assign req       = reqRead | reqWrite;
  assign phaseLast = (phaseCnt == 3'(WAIT_CYCLES));
  assign rdWord    = {hiHalf, loHalf};

  always_comb begin
    nextState = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) nextState = LO;
      end
      LO:      if (phaseLast) nextState = HI;
      HI:      if (phaseLast) nextState = DONE;
      DONE: begin
        ready     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phaseCnt  <= 3'd0;
      loHalf    <= 16'h0;
      hiHalf    <= 16'h0;
      sramAddr  <= '0;
      sramDqOut <= 16'h0;
      sramDqOe  <= 1'b0;
      sramWeN   <= 1'b1;
    end else begin
      state <= nextState;

      // Counter runs only inside a phase and restarts at 0 for the next one
      if ((state == LO || state == HI) && !phaseLast)
        phaseCnt <= phaseCnt + 3'd1;
      else
        phaseCnt <= 3'd0;

      // SRAM data is sampled at the end of each phase, giving it the full phase to settle
      if (state == LO && phaseLast && reqRead) loHalf <= sramDqIn;
      if (state == HI && phaseLast && reqRead) hiHalf <= sramDqIn;

      // Pins are registered from the next state so they line up with the phase itself
      case (nextState)
        LO: begin
          sramAddr  <= {wordAddr, 1'b0};
          sramDqOut <= wrData[15:0];
          sramDqOe  <= reqWrite;
          sramWeN   <= ~reqWrite;
        end
        HI: begin
          sramAddr  <= {wordAddr, 1'b1};
          sramDqOut <= wrData[31:16];
          sramDqOe  <= reqWrite;
          sramWeN   <= ~reqWrite;
        end
        default: begin
          sramDqOe <= 1'b0;
          sramWeN  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/stage_mem.sv
// Memory stage: address mapping, SRAM load/store via sram_ctrl, and the MEM/WB register.
// Latency: 1 cycle for non-memory ops; memory ops write back on the edge after DONE.
// Backpressure: ready low freezes earlier stages; MEM/WB inserts bubbles meanwhile.
//
// Ports: clk/rst (sync, active-high); EX/MEM inputs wbEnIn, memReadIn, memWriteIn,
// destIn, aluResIn, valRmIn; ready to the pipeline; wbWbEn/wbValue/wbDest to ID;
// sramAddr/sramDqOut/sramDqIn/sramDqOe/sramWeN to the external SRAM.
import pipe_pkg::*;

module stage_mem #(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wbEnIn,
  input  logic               memReadIn,
  input  logic               memWriteIn,
  input  logic [3:0]         destIn,
  input  logic [31:0]        aluResIn,
  input  logic [31:0]        valRmIn,
  output logic               ready,
  output logic               wbWbEn,
  output logic [31:0]        wbValue,
  output logic [3:0]         wbDest,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN
);

  logic               wrEff;
  logic [31:0]        byteOff;
  logic [SRAM_AW-2:0] wordAddr;
  logic               unusedOffBits;
  logic [31:0]        rdWord;
  wbBus_t             wbReg;

  // A simultaneous read and write is executed as a read only
  assign wrEff = memWriteIn & ~memReadIn;

  // Word index wraps modulo the SRAM size; byte-lane bits are ignored
  assign byteOff       = aluResIn - BASE_ADDR;
  assign wordAddr      = byteOff[SRAM_AW:2];
  assign unusedOffBits = ^{byteOff[31:SRAM_AW+1], byteOff[1:0]};

  sram_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .SRAM_AW    (SRAM_AW)
  ) uCtrl (
    .clk      (clk),
    .rst      (rst),
    .reqRead  (memReadIn),
    .reqWrite (wrEff),
    .wordAddr (wordAddr),
    .wrData   (valRmIn),
    .ready    (ready),
    .rdWord   (rdWord),
    .sramAddr (sramAddr),
    .sramDqOut(sramDqOut),
    .sramDqIn (sramDqIn),
    .sramDqOe (sramDqOe),
    .sramWeN  (sramWeN)
  );

  // MEM/WB register: a stalled cycle becomes a bubble, data fields hold
  always_ff @(posedge clk) begin
    if (rst) begin
      wbReg <= '0;
    end else if (ready) begin
      wbReg.wbEn  <= wbEnIn & ~wrEff;
      wbReg.value <= memReadIn ? rdWord : aluResIn;
      wbReg.dest  <= destIn;
    end else begin
      wbReg.wbEn <= 1'b0;
    end
  end

  assign wbWbEn  = wbReg.wbEn;
  assign wbValue = wbReg.value;
  assign wbDest  = wbReg.dest;

endmodule
